seq_det_scheduler: RTL and testbench
====================================

# seq_det_scheduler

Shares one serial pattern-match engine among NCH independent bit-serial input channels. A round-robin arbiter grants one channel per cycle. The engine advances that channel's saved match context: a history shift register plus a fill count. Matches are reported as a tagged one-cycle pulse, and per-channel saturating match counters are kept. The block sits between the serial front-ends and the status/interrupt logic. It replaces one dedicated detector FSM per channel.

## Interface
- NCH, 4: number of channels (2..16)
- PAT_W, 4: pattern length in bits (1..16)
- PATTERN, 4'b1011: pattern to match; MSB is the first bit received
- CNT_W, 8: width of each per-channel match counter
- clock  input  1  clock
- reset  input  1  asynchronous, active-high
- enable  input  1  when low, no grants are issued
- ch_valid  input  NCH  channel i has a bit on ch_bit[i]
- ch_bit  input  NCH  serial data bit per channel
- ch_ready  output  NCH  one-hot grant; a transfer occurs when ch_valid[i] and ch_ready[i] are both high
- ch_clear  input  NCH  synchronous clear of channel i's context and counter
- match_valid  output  1  one-cycle pulse indicating a pattern match
- match_ch  output  clog2(NCH)  channel that matched; qualified by match_valid
- cnt_sel  input  clog2(NCH)  counter read select
- cnt_out  output  CNT_W  combinational read of counter[cnt_sel]

## Operation
- Arbiter: last_grant pointer; the search starts at last_grant+1 modulo NCH.
  - The first i with ch_valid[i], !ch_clear[i] and enable gets ch_ready[i]=1; all other bits are 0.
  - ch_ready is combinational from these inputs and the registered pointer.
  - The pointer updates only on a transfer.
- Accept of a bit b on channel g:
  - hist[g] <= {hist[g][PAT_W-2:0], b}
  - fill[g] <= min(fill[g]+1, PAT_W)
- Match: the post-update fill equals PAT_W and the post-update hist equals PATTERN.
  - On a match: match_valid=1, match_ch=g, and counter[g] increments, saturating at 2^CNT_W-1.
- ch_clear[i]: hist, fill and counter of channel i go to 0.
  - ch_ready[i] is forced low in the same cycle, so no bit is lost silently.
- Channels not granted keep their context unchanged, regardless of ch_bit activity.

## Timing
- Reset values: ch_ready=0 while reset is held; match_valid=0; match_ch=0; all hist, fill and counters 0; last_grant=NCH-1, so channel 0 wins first.
- ch_ready responds combinationally once reset is released.
- One transfer per cycle maximum. Throughput per channel under full load is 1 bit per NCH cycles.
- Latency: match_valid and match_ch are registered and assert in the cycle after the edge that accepted the completing bit. They are held for exactly one cycle.
- cnt_out reflects the incremented value in that same cycle.
- ch_clear[i] in the cycle after channel i's completing accept: the match pulse still fires; the counter ends at 0, because clear wins over increment.
- Reset mid-stream discards all partial history immediately.
- enable low: no grants; contexts and counters are held.

## Configuration
- SEQ_SCHED_OVERLAP_EN defined: after a match, hist and fill are kept, so overlapping occurrences count. Example: 1011011 gives 2 matches.
- SEQ_SCHED_OVERLAP_EN undefined: a match resets fill[g] and hist[g] to 0, so detection is non-overlapping. Example: 1011011 gives 1 match.

## Structure
- Package seq_det_pkg holds:
  - default PAT_W, PATTERN, CNT_W
  - a function for the pointer width, clog2(NCH)
  - a typedef for the channel context struct {hist, fill}
- One sub-module: seq_rr_arbiter, parameterised by NCH. Inputs are req and advance; outputs are a one-hot grant and the grant index.
- The context array, match compare and counters stay in the top level.

## Test plan
- Channel 0 only, bits 1,0,1,1 → match_valid pulses once, 1 cycle after the 4th accept; match_ch=0; cnt_out(sel=0)=1.
- All four channels continuously valid → grants 0,1,2,3,0,1…, with each ch_ready high exactly every 4th cycle. No match from a 1011 that is interleaved across channels.
- Channel 2 stream 1011011:
  - 2 matches with SEQ_SCHED_OVERLAP_EN defined.
  - 1 match without it.
- CNT_W=2, 5 matches on channel 1 → cnt_out saturates at 3; match_valid still pulses 5 times.
- Channel 0 bits 1,0,1, then reset asserted for 1 cycle, then bit 1 → no match; all counters read 0.
- ch_clear[3] asserted with ch_valid[3] high → ch_ready[3]=0 in that cycle, and the grant goes to the next valid channel. The next sequence 1,0,1,1 on channel 3 gives count 1.

Source files
------------

// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared defaults, pointer-width helper and per-channel
//                context type for the shared serial pattern-match engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    localparam int               c_DEF_PAT_W   = 4;
    localparam logic [3:0]       c_DEF_PATTERN = 4'b1011;
    localparam int               c_DEF_CNT_W   = 8;

    // Context storage is sized for the largest supported pattern; the engine
    // masks the history down to the configured PAT_W.
    localparam int               c_MAX_PAT_W   = 16;
    localparam int               c_FILL_W      = 5;

    // Width of a channel index; a 2-channel build still needs one bit.
    function automatic int seq_ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [c_MAX_PAT_W-1:0] hist;
        logic [c_FILL_W-1:0]    fill;
    } seq_ctx_t;

endpackage
`default_nettype wire

// File: rtl/seq_det_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_scheduler_if
//  Description : Channel handshake and match-report bundle between the serial
//                front-ends (master) and the scheduler (slave).
//                ch_valid/ch_bit/ch_clear : front-end -> scheduler
//                ch_ready                 : one-hot grant back to front-ends
//                match_valid/match_ch     : tagged one-cycle match pulse
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_det_scheduler_if #(
    parameter int NCH   = 4,
    parameter int PTR_W = 2
);
    logic [NCH-1:0]   ch_valid;
    logic [NCH-1:0]   ch_bit;
    logic [NCH-1:0]   ch_clear;
    logic [NCH-1:0]   ch_ready;
    logic             match_valid;
    logic [PTR_W-1:0] match_ch;

    modport master (
        output ch_valid, ch_bit, ch_clear,
        input  ch_ready, match_valid, match_ch
    );

    modport slave (
        input  ch_valid, ch_bit, ch_clear,
        output ch_ready, match_valid, match_ch
    );
endinterface
`default_nettype wire

// File: rtl/seq_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : seq_rr_arbiter
//  Description : Round-robin arbiter. Search starts one past the last granted
//                index; the pointer moves only when i_advance confirms that
//                the grant was used.
//  Ports       : clock, reset (async, active-high)
//                i_req[NCH]     request vector
//                i_advance      grant was consumed this cycle
//                o_grant[NCH]   one-hot grant (combinational)
//                o_grant_idx    index of the granted request
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_rr_arbiter
    import seq_det_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int PTR_W = seq_ptr_w(NCH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NCH-1:0]   i_req,
    input  logic             i_advance,
    output logic [NCH-1:0]   o_grant,
    output logic [PTR_W-1:0] o_grant_idx
);

    logic [PTR_W-1:0] r_last;
    logic [NCH-1:0]   w_grant;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;
    int               w_cand;

    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int k = 1; k <= NCH; k++) begin
            w_cand = (int'(r_last) + k) % NCH;
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                w_idx           = PTR_W'(w_cand);
                w_grant[w_cand] = 1'b1;
            end
        end
    end

    // Reset points at the last channel so channel 0 is searched first.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last <= PTR_W'(NCH - 1);
        end else if (i_advance && w_found) begin
            r_last <= w_idx;
        end
    end

    assign o_grant     = w_grant;
    assign o_grant_idx = w_idx;

endmodule
`default_nettype wire

// File: rtl/seq_det_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_scheduler
//  Description : One serial pattern matcher time-shared across NCH bit-serial
//                channels. Each channel keeps a history/fill context and a
//                saturating match counter; matches are reported as a
//                registered, channel-tagged one-cycle pulse.
//  Ports       : clock, reset (async, active-high), enable (grant gate)
//                bus      seq_det_scheduler_if.slave (handshake + match pulse)
//                cnt_sel  counter read select
//                cnt_out  counter[cnt_sel], combinational
//  Config      : SEQ_SCHED_OVERLAP_EN - keep context after a match so
//                overlapping occurrences are counted; undefined clears it.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_det_scheduler
    import seq_det_pkg::*;
#(
    parameter int               NCH     = 4,
    parameter int               PAT_W   = c_DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(c_DEF_PATTERN),
    parameter int               CNT_W   = c_DEF_CNT_W
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [seq_ptr_w(NCH)-1:0]   cnt_sel,
    output logic [CNT_W-1:0]            cnt_out,
    seq_det_scheduler_if.slave          bus
);

    localparam int                     PTR_W       = seq_ptr_w(NCH);
    localparam logic [c_MAX_PAT_W-1:0] c_HIST_MASK =
        c_MAX_PAT_W'((64'd1 << PAT_W) - 64'd1);
    localparam logic [c_FILL_W-1:0]    c_FILL_FULL = c_FILL_W'(PAT_W);

    seq_ctx_t          r_ctx [NCH];
    logic [CNT_W-1:0]  r_cnt [NCH];
    logic              r_match_valid;
    logic [PTR_W-1:0]  r_match_ch;

    logic [NCH-1:0]         w_req;
    logic [NCH-1:0]         w_grant;
    logic [PTR_W-1:0]       w_gidx;
    logic                   w_xfer;
    seq_ctx_t               w_cur;
    logic                   w_bit;
    logic [c_MAX_PAT_W-1:0] w_new_hist;
    logic [c_FILL_W-1:0]    w_new_fill;
    logic                   w_match;
    seq_ctx_t               w_next_ctx;

    // A channel being cleared is never granted, so its bit is not consumed
    // by a context that is about to be wiped.
    assign w_req = {NCH{enable & ~reset}} & bus.ch_valid & ~bus.ch_clear;

    seq_rr_arbiter #(
        .NCH   (NCH),
        .PTR_W (PTR_W)
    ) u_arb (
        .clock       (clock),
        .reset       (reset),
        .i_req       (w_req),
        .i_advance   (w_xfer),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx)
    );

    // Grants are only issued to valid channels, so any grant is a transfer.
    assign w_xfer = |w_grant;
    assign w_cur  = r_ctx[w_gidx];
    assign w_bit  = bus.ch_bit[w_gidx];

    assign w_new_hist = {w_cur.hist[c_MAX_PAT_W-2:0], w_bit} & c_HIST_MASK;
    assign w_new_fill = (w_cur.fill >= c_FILL_FULL) ? c_FILL_FULL
                                                    : w_cur.fill + 1'b1;
    assign w_match    = w_xfer && (w_new_fill == c_FILL_FULL) &&
                        (w_new_hist == c_MAX_PAT_W'(PATTERN));

    always_comb begin
        w_next_ctx.hist = w_new_hist;
        w_next_ctx.fill = w_new_fill;
`ifdef SEQ_SCHED_OVERLAP_EN
        // Context retained: the tail of this match may start the next one.
`else
        if (w_match) begin
            w_next_ctx = '0;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_match_valid <= 1'b0;
            r_match_ch    <= '0;
            for (int i = 0; i < NCH; i++) begin
                r_ctx[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else begin
            r_match_valid <= w_match;
            if (w_match) begin
                r_match_ch <= w_gidx;
            end
            for (int i = 0; i < NCH; i++) begin
                if (bus.ch_clear[i]) begin
                    r_ctx[i] <= '0;
                    r_cnt[i] <= '0;
                end else if (w_xfer && (w_gidx == PTR_W'(i))) begin
                    r_ctx[i] <= w_next_ctx;
                    if (w_match && (r_cnt[i] != {CNT_W{1'b1}})) begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.ch_ready    = w_grant;
    assign bus.match_valid = r_match_valid;
    assign bus.match_ch    = r_match_ch;
    assign cnt_out         = r_cnt[cnt_sel];

endmodule
`default_nettype wire

// File: tb/tb_seq_det_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_det_scheduler
//  Description : Self-checking bench for seq_det_scheduler. A default instance
//                (CNT_W=8) and a narrow-counter instance (CNT_W=2) share the
//                clock, reset and enable. Expected match pulses are queued as
//                bits are accepted and matched against the DUT pulse stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_det_scheduler;
    import seq_det_pkg::*;

    logic       clock  = 1'b0;
    logic       reset  = 1'b1;
    logic       enable = 1'b1;
    logic [1:0] cnt_sel   = '0;
    logic [7:0] cnt_out;
    logic [1:0] cnt_sel_s = '0;
    logic [1:0] cnt_out_s;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int sat_pulses = 0;

    seq_det_scheduler_if #(.NCH(4), .PTR_W(2)) ifa ();
    seq_det_scheduler_if #(.NCH(4), .PTR_W(2)) ifb ();

    seq_det_scheduler #(
        .NCH(4), .PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .cnt_sel (cnt_sel),
        .cnt_out (cnt_out),
        .bus     (ifa.slave)
    );

    seq_det_scheduler #(
        .NCH(4), .PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)
    ) dut_s (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .cnt_sel (cnt_sel_s),
        .cnt_out (cnt_out_s),
        .bus     (ifb.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- reference model + scoreboard ----------------
    typedef struct { int ch; int cyc; } exp_t;
    exp_t       exp_q[$];
    logic [3:0] m_hist [4];
    int         m_fill [4];
    int         m_last;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_hist[i] = '0;
            m_fill[i] = 0;
        end
        m_last = 3;
    endtask

    task automatic model_clear(input int ch);
        m_hist[ch] = '0;
        m_fill[ch] = 0;
    endtask

    // Called at the falling edge before the accepting rising edge.
    task automatic model_accept(input int ch, input logic b);
        exp_t e;
        m_hist[ch] = {m_hist[ch][2:0], b};
        if (m_fill[ch] < 4) m_fill[ch]++;
        m_last = ch;
        if (m_fill[ch] == 4 && m_hist[ch] == 4'b1011) begin
            e.ch  = ch;
            e.cyc = cyc + 1;
            exp_q.push_back(e);
`ifndef SEQ_SCHED_OVERLAP_EN
            m_hist[ch] = '0;
            m_fill[ch] = 0;
`endif
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (ifa.match_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_match: match_ch=%0d at cycle %0d, required no pulse",
                         ifa.match_ch, cyc);
            end else begin
                e = exp_q.pop_front();
                if (ifa.match_ch !== 2'(e.ch) || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL match_tag: got ch=%0d cycle=%0d, required ch=%0d cycle=%0d",
                             ifa.match_ch, cyc, e.ch, e.cyc);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missed_match: no pulse at cycle %0d, required ch=%0d at cycle %0d",
                     cyc, e.ch, e.cyc);
        end
        if (ifb.match_valid === 1'b1) sat_pulses++;
    end

    // Offer one bit on a channel until granted; returns at the falling edge
    // following the accepting edge (the cycle a match pulse would be visible).
    task automatic send_bit(input int ch, input logic b);
        int n;
        @(negedge clock);
        ifa.ch_valid[ch] = 1'b1;
        ifa.ch_bit[ch]   = b;
        #1;
        n = 0;
        while (ifa.ch_ready[ch] !== 1'b1 && n < 20) begin
            @(negedge clock);
            #1;
            n++;
        end
        checks++;
        if (ifa.ch_ready[ch] !== 1'b1) begin
            errors++;
            $display("FAIL grant_timeout ch%0d: ch_ready=%b, required a grant within 20 cycles",
                     ch, ifa.ch_ready);
        end else begin
            model_accept(ch, b);
        end
        @(negedge clock);
        ifa.ch_valid[ch] = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        ifa.ch_valid = 4'b1111;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (ifa.ch_ready !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ready: got %b, required 0000", ifa.ch_ready);
        end
        checks++;
        if (ifa.match_valid !== 1'b0 || ifa.match_ch !== 2'd0) begin
            errors++;
            $display("FAIL reset_match: got valid=%b ch=%0d, required 0/0",
                     ifa.match_valid, ifa.match_ch);
        end
        @(negedge clock);
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            #1;
            checks++;
            if (cnt_out !== 8'd0) begin
                errors++;
                $display("FAIL reset_cnt%0d: got %0d, required 0", s, cnt_out);
            end
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (ifa.ch_ready !== 4'b0001) begin
            errors++;
            $display("FAIL first_grant: got %b, required 0001", ifa.ch_ready);
        end
        ifa.ch_valid = 4'b0000;
    endtask

    task automatic test_single_match();
        cnt_sel = 2'd0;
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        send_bit(0, 1'b1);
        #1;
        checks++;
        if (ifa.match_valid !== 1'b1 || cnt_out !== 8'd1) begin
            errors++;
            $display("FAIL single_match: got valid=%b cnt=%0d, required 1/1",
                     ifa.match_valid, cnt_out);
        end
        @(negedge clock);
        #1;
        checks++;
        if (ifa.match_valid !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: match_valid=%b second cycle, required 0",
                     ifa.match_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] bits;
        logic [3:0] exp_rdy;
        int         idx;
        bits = 4'b1101;
        @(negedge clock);
        ifa.ch_bit   = bits;
        ifa.ch_valid = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            #1;
            idx     = (m_last + 1) % 4;
            exp_rdy = 4'(1 << idx);
            checks++;
            if (ifa.ch_ready !== exp_rdy) begin
                errors++;
                $display("FAIL rr_grant step %0d: got %b, required %b", k, ifa.ch_ready, exp_rdy);
            end
            model_accept(idx, bits[idx]);
            @(negedge clock);
        end
        ifa.ch_valid = 4'b0000;
    endtask

    task automatic do_clear(input int ch);
        @(negedge clock);
        ifa.ch_clear[ch] = 1'b1;
        model_clear(ch);
        @(negedge clock);
        ifa.ch_clear[ch] = 1'b0;
    endtask

    task automatic test_overlap();
        logic [6:0] stream;
        int         exp_cnt;
        stream = 7'b1011011;
`ifdef SEQ_SCHED_OVERLAP_EN
        exp_cnt = 2;
`else
        exp_cnt = 1;
`endif
        do_clear(2);
        for (int k = 6; k >= 0; k--) send_bit(2, stream[k]);
        repeat (2) @(negedge clock);
        cnt_sel = 2'd2;
        #1;
        checks++;
        if (cnt_out !== 8'(exp_cnt)) begin
            errors++;
            $display("FAIL overlap_count: got %0d, required %0d", cnt_out, exp_cnt);
        end
    endtask

    task automatic test_reset_midstream();
        send_bit(0, 1'b1);
        send_bit(0, 1'b0);
        send_bit(0, 1'b1);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        send_bit(0, 1'b1);
        repeat (2) @(negedge clock);
        for (int s = 0; s < 4; s++) begin
            cnt_sel = 2'(s);
            #1;
            checks++;
            if (cnt_out !== 8'd0) begin
                errors++;
                $display("FAIL midreset_cnt%0d: got %0d, required 0", s, cnt_out);
            end
        end
    endtask

    task automatic test_enable();
        @(negedge clock);
        enable = 1'b0;
        ifa.ch_valid = 4'b0101;
        #1;
        checks++;
        if (ifa.ch_ready !== 4'b0000) begin
            errors++;
            $display("FAIL enable_low: got %b, required 0000", ifa.ch_ready);
        end
        @(negedge clock);
        enable = 1'b1;
        #1;
        // Pointer was left at channel 0, so channel 2 is next among {0,2}.
        checks++;
        if (ifa.ch_ready !== 4'b0100) begin
            errors++;
            $display("FAIL enable_high: got %b, required 0100", ifa.ch_ready);
        end
        ifa.ch_valid = 4'b0000;
    endtask

    task automatic test_clear();
        @(negedge clock);
        ifa.ch_bit   = 4'b0000;
        ifa.ch_valid = 4'b1001;
        ifa.ch_clear = 4'b1000;
        #1;
        checks++;
        if (ifa.ch_ready !== 4'b0001) begin
            errors++;
            $display("FAIL clear_grant: got %b, required 0001", ifa.ch_ready);
        end
        model_clear(3);
        model_accept(0, 1'b0);
        @(negedge clock);
        ifa.ch_valid = 4'b0000;
        ifa.ch_clear = 4'b0000;
        cnt_sel = 2'd3;
        send_bit(3, 1'b1);
        send_bit(3, 1'b0);
        send_bit(3, 1'b1);
        send_bit(3, 1'b1);
        #1;
        checks++;
        if (cnt_out !== 8'd1) begin
            errors++;
            $display("FAIL clear_then_match: got %0d, required 1", cnt_out);
        end
        // Clear in the pulse cycle: the counter must end at zero.
        ifa.ch_clear[3] = 1'b1;
        model_clear(3);
        @(negedge clock);
        ifa.ch_clear[3] = 1'b0;
        #1;
        checks++;
        if (cnt_out !== 8'd0) begin
            errors++;
            $display("FAIL clear_wins: got %0d, required 0", cnt_out);
        end
    endtask

    task automatic test_saturation();
        logic [3:0] pat;
        pat = 4'b1011;
        cnt_sel_s = 2'd1;
        @(negedge clock);
        for (int k = 0; k < 20; k++) begin
            ifb.ch_valid[1] = 1'b1;
            ifb.ch_bit[1]   = pat[3 - (k % 4)];
            #1;
            checks++;
            if (ifb.ch_ready !== 4'b0010) begin
                errors++;
                $display("FAIL sat_grant step %0d: got %b, required 0010", k, ifb.ch_ready);
            end
            @(negedge clock);
        end
        ifb.ch_valid = 4'b0000;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (sat_pulses != 5) begin
            errors++;
            $display("FAIL sat_pulses: got %0d, required 5", sat_pulses);
        end
        checks++;
        if (cnt_out_s !== 2'd3) begin
            errors++;
            $display("FAIL sat_count: got %0d, required 3", cnt_out_s);
        end
    endtask

    initial begin
        ifa.ch_valid = '0; ifa.ch_bit = '0; ifa.ch_clear = '0;
        ifb.ch_valid = '0; ifb.ch_bit = '0; ifb.ch_clear = '0;
        model_reset();
        test_reset();
        test_single_match();
        test_round_robin();
        test_overlap();
        test_reset_midstream();
        test_enable();
        test_clear();
        test_saturation();
        repeat (2) @(negedge clock);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_matches: %0d still queued, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
